conv_operand_feeder: RTL
========================

// Module: conv_operand_feeder
// PURPOSE
//  - Memory-side responder to the transposed-conv controller's read strobes (wgt_read, ifm_read).
//  - Generates weight/IFM SRAM addresses and returns operands to the PE array.
//  - Weight order: filter, channel, k*k. IFM order: channel, pixel; the IFM is rewound once per filter.
//  - Sits between the controller plus PE array and the weight/IFM SRAMs (sync read, 1-cycle latency).
// PARAMETERS
//  DATA_W       8   operand width
//  KERNEL_SIZE  4   kernel edge K
//  IFM_SIZE     9   padded IFM edge
//  PAD          2   padding; real pixels per channel PIX=(IFM_SIZE-2*PAD)^2 (=25)
//  CI           3   input channels
//  CO           4   output filters
//  ADDR_W       10  SRAM address width; must hold CO*CI*K*K-1 and CI*PIX-1
// PORTS
//  clk1          in   1       single clock, rising edge
//  rst           in   1       asynchronous, active-high reset
//  start_conv    in   1       pulse: clear counters, enter RUN
//  wgt_read      in   1       weight fetch strobe, one word per cycle high
//  ifm_read      in   1       IFM fetch strobe, one word per cycle high
//  wgt_mem_en    out  1       weight SRAM read enable
//  wgt_mem_addr  out  ADDR_W  weight SRAM address
//  wgt_mem_rdata in   DATA_W  weight SRAM data, valid 1 cycle after en
//  ifm_mem_en    out  1       IFM SRAM read enable
//  ifm_mem_addr  out  ADDR_W  IFM SRAM address
//  ifm_mem_rdata in   DATA_W  IFM SRAM data, valid 1 cycle after en
//  wgt_data      out  DATA_W  weight to PE array
//  wgt_valid     out  1       wgt_data valid, 1-cycle pulse per word
//  ifm_data      out  DATA_W  pixel to PE array
//  ifm_valid     out  1       ifm_data valid, 1-cycle pulse per word
//  filter_idx    out  4       current filter, 0..CO-1
//  busy          out  1       high in RUN
//  done          out  1       1-cycle pulse at end of job
//  err           out  1       sticky protocol error; tied 0 unless ERR_CHECK_EN
// BEHAVIOUR
//  Reset: FSM goes to IDLE. All outputs 0, all counters 0.
//  FSM states:
//   - IDLE -> RUN on start_conv.
//   - RUN -> IDLE on the cycle the final IFM word is delivered; done pulses that cycle.
//   - start_conv in RUN restarts the job:
//     - counters are cleared and filter_idx goes to 0;
//     - in-flight valids are squashed, so nothing is emitted for strobes issued before the restart.
//  Strobe handling:
//   - Strobes are honoured only in RUN.
//   - mem_en = strobe & RUN, combinational.
//   - mem_addr = current counter, registered.
//  Counters and latency:
//   - Each honoured strobe advances its counter by 1.
//   - Data is registered from rdata, so *_valid and *_data appear 2 cycles after the strobe.
//   - Back-to-back strobes give one word per cycle.
//   - Weight and IFM paths are fully independent; simultaneous strobes are both served in the same cycle.
//  Weight address: wgt_cnt runs 0..CO*CI*K*K-1, then wraps to 0 (no error).
//  IFM address:
//   - ifm_cnt runs 0..CI*PIX-1; address = ch*PIX + pix.
//   - When ifm_cnt wraps to 0, filter_idx increments.
//   - The wrap that completes filter CO-1 marks the final word. Its data leaves 2 cycles later with done.
//  Boundaries:
//   - Strobes in IDLE produce no mem_en and no valid.
//   - start_conv together with a strobe: start wins and the strobe is dropped.
//   - Reset mid-job: immediate return to IDLE, no done.
//  Widths: counters are ADDR_W bits, compared with ==, never overflow-wrapped.
// CONFIGURATION
//  ERR_CHECK_EN defined:
//   - err sets on a strobe in IDLE, or on an ifm_read after the final word.
//   - err is sticky and clears on start_conv or rst.
//  ERR_CHECK_EN undefined:
//   - err is constant 0 and the illegal strobes are silently ignored.
// TESTING
//  T1 reset: assert rst mid-run -> busy=done=err=0, all *_en/*_valid=0, filter_idx=0, addrs 0.
//  T2 start, wgt_read at cycle t -> wgt_mem_en=1,addr=0 at t; wgt_valid=1,wgt_data=mem[0] at t+2 only.
//  T3 26 back-to-back ifm_read -> addrs 0..25 (25 = ch1 pix0); 26 consecutive ifm_valid, data in order.
//  T4 full job, 192 wgt_read + 300 ifm_read -> ifm addr wraps to 0 after 75, 150, 225;
//     filter_idx steps 1,2,3; done coincident with 300th ifm_valid; busy=0 next cycle.
//  T5 start_conv 1 cycle after an ifm_read -> that strobe's ifm_valid suppressed; next ifm_read gets addr 0.
//  T6 ERR_CHECK_EN: ifm_read in IDLE -> no mem_en, err=1, holds until start_conv; macro off -> err stays 0.

Source files
------------

// File: rtl/conv_operand_feeder.sv
// Operand feeder for the transposed-conv datapath: turns controller read strobes into
// weight/IFM SRAM reads and returns registered operands. Optional ERR_CHECK_EN adds a sticky protocol-error flag.
module conv_operand_feeder #(
  parameter int DATA_W      = 8,
  parameter int KERNEL_SIZE = 4,
  parameter int IFM_SIZE    = 9,
  parameter int PAD         = 2,
  parameter int CI          = 3,
  parameter int CO          = 4,
  parameter int ADDR_W      = 10
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              start_conv,
  input  logic              wgt_read,
  input  logic              ifm_read,
  output logic              wgt_mem_en,
  output logic [ADDR_W-1:0] wgt_mem_addr,
  input  logic [DATA_W-1:0] wgt_mem_rdata,
  output logic              ifm_mem_en,
  output logic [ADDR_W-1:0] ifm_mem_addr,
  input  logic [DATA_W-1:0] ifm_mem_rdata,
  output logic [DATA_W-1:0] wgt_data,
  output logic              wgt_valid,
  output logic [DATA_W-1:0] ifm_data,
  output logic              ifm_valid,
  output logic [3:0]        filter_idx,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int WGT_WORDS = CO * CI * KERNEL_SIZE * KERNEL_SIZE;
  localparam int PIX       = (IFM_SIZE - 2 * PAD) * (IFM_SIZE - 2 * PAD);
  localparam int IFM_WORDS = CI * PIX;

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;

  logic              run;
  logic              wgt_take, ifm_take, ifm_wrap, last_issued;
  logic [ADDR_W-1:0] wgt_cnt, ifm_cnt;
  logic              wgt_p1, ifm_p1, last_p1;

  // Handshake: a strobe is a one-cycle request with no back-pressure; the feeder always
  // accepts it in RUN (unless start_conv wins), and the word returns exactly 2 cycles later.
  assign run      = (state == RUN);
  assign wgt_take = wgt_read & run & ~start_conv;
  assign ifm_take = ifm_read & run & ~start_conv & ~last_issued;
  assign ifm_wrap = (ifm_cnt == ADDR_W'(IFM_WORDS - 1));

  assign wgt_mem_en   = wgt_take;
  assign ifm_mem_en   = ifm_take;
  assign wgt_mem_addr = wgt_cnt;
  assign ifm_mem_addr = ifm_cnt;
  assign busy         = run;

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_conv) state_nxt = RUN;
      RUN:     if (!start_conv && done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address counters; the IFM counter is linear, so ch*PIX+pix falls out directly.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      wgt_cnt     <= '0;
      ifm_cnt     <= '0;
      filter_idx  <= '0;
      last_issued <= 1'b0;
    end else if (start_conv) begin
      wgt_cnt     <= '0;
      ifm_cnt     <= '0;
      filter_idx  <= '0;
      last_issued <= 1'b0;
    end else begin
      if (wgt_take)
        wgt_cnt <= (wgt_cnt == ADDR_W'(WGT_WORDS - 1)) ? '0 : wgt_cnt + 1'b1;
      if (ifm_take) begin
        if (ifm_wrap) begin
          ifm_cnt <= '0;
          if (filter_idx == 4'(CO - 1)) last_issued <= 1'b1;
          else                          filter_idx  <= filter_idx + 4'd1;
        end else begin
          ifm_cnt <= ifm_cnt + 1'b1;
        end
      end
    end
  end

  // Return pipeline: stage 1 tracks the SRAM access, stage 2 registers rdata.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      wgt_p1    <= 1'b0;
      ifm_p1    <= 1'b0;
      last_p1   <= 1'b0;
      wgt_valid <= 1'b0;
      ifm_valid <= 1'b0;
      done      <= 1'b0;
      wgt_data  <= '0;
      ifm_data  <= '0;
    end else if (start_conv) begin
      wgt_p1    <= 1'b0;
      ifm_p1    <= 1'b0;
      last_p1   <= 1'b0;
      wgt_valid <= 1'b0;
      ifm_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      wgt_p1    <= wgt_take;
      ifm_p1    <= ifm_take;
      last_p1   <= ifm_take & ifm_wrap & (filter_idx == 4'(CO - 1));
      wgt_valid <= wgt_p1;
      ifm_valid <= ifm_p1;
      done      <= last_p1;
      if (wgt_p1) wgt_data <= wgt_mem_rdata;
      if (ifm_p1) ifm_data <= ifm_mem_rdata;
    end
  end

`ifdef ERR_CHECK_EN
  logic illegal;
  assign illegal = (~run & (wgt_read | ifm_read)) | (ifm_read & last_issued);

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst)             err <= 1'b0;
    else if (start_conv) err <= 1'b0;
    else if (illegal)    err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule
